// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store unit. Accepts one load/store from EX and runs a
// req/ack transaction on the data bus. The pipeline is stalled until the
// transaction finishes. Store data is placed on the correct byte lanes, and
// load data is extracted and sign/zero-extended. Misaligned requests and bus
// timeouts raise a one-cycle exception pulse; they do not issue or hang.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ex_mem_en,
    input  logic              i_ex_mem_we,
    input  logic [2:0]        i_ex_funct3,
    input  logic [ADDR_W-1:0] i_ex_alu_out,
    input  logic [DATA_W-1:0] i_ex_store_data,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_ack,
    output logic              o_mem_stall,
    output logic [DATA_W-1:0] o_mem_data_to_gpr,
    output logic              o_misalign_exc,
    output logic              o_bus_err_exc
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic        r_is_b;
    logic        r_is_h;
    logic        r_uns;
    logic [1:0]  r_lane;

    logic              w_is_b;
    logic              w_is_h;
    logic              w_uns;
    logic              w_misalign;
    logic              w_accept;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;

    // Decode the access size. BU/HU are load-only encodings. Any undefined
    // encoding, or BU/HU used with a store, falls back to a word access.
    always_comb begin
        w_is_b     = (i_ex_funct3[1:0] == 2'b00) && (!i_ex_funct3[2] || !i_ex_mem_we);
        w_is_h     = (i_ex_funct3[1:0] == 2'b01) && (!i_ex_funct3[2] || !i_ex_mem_we);
        w_uns      = i_ex_funct3[2] && !i_ex_mem_we && (w_is_b || w_is_h);
        w_misalign = w_is_b ? 1'b0 :
                     w_is_h ? i_ex_alu_out[0] : (i_ex_alu_out[1:0] != 2'b00);
        w_accept   = (r_state == IDLE) && i_ex_mem_en && !w_misalign;
        w_be       = w_is_b ? (4'b0001 << i_ex_alu_out[1:0]) :
                     w_is_h ? (4'b0011 << i_ex_alu_out[1:0]) : 4'b1111;
        w_wdata    = w_is_b ? {4{i_ex_store_data[7:0]}} :
                     w_is_h ? {2{i_ex_store_data[15:0]}} : i_ex_store_data;
    end

    // Select the addressed lane of the read data and extend it to full width.
    always_comb begin
        w_byte = i_bus_rdata[8*r_lane +: 8];
        w_half = r_lane[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        if (r_is_b)
            w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        else if (r_is_h)
            w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        else
            w_load = i_bus_rdata;
    end

    // The stall must be high during the accept cycle, before any state has
    // changed, so it is combinational. It is low in DONE so that EX/MEM can
    // capture the result.
    assign o_mem_stall = w_accept || (r_state == ACCESS);

    // Transaction FSM. The bus outputs are registered and held for the whole
    // ACCESS state. They are cleared when the transaction ends.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state           <= IDLE;
            r_cnt             <= 8'd0;
            r_we              <= 1'b0;
            r_is_b            <= 1'b0;
            r_is_h            <= 1'b0;
            r_uns             <= 1'b0;
            r_lane            <= 2'd0;
            o_bus_req         <= 1'b0;
            o_bus_we          <= 1'b0;
            o_bus_addr        <= '0;
            o_bus_be          <= 4'd0;
            o_bus_wdata       <= '0;
            o_mem_data_to_gpr <= '0;
            o_misalign_exc    <= 1'b0;
            o_bus_err_exc     <= 1'b0;
        end else begin
            o_misalign_exc <= 1'b0;
            o_bus_err_exc  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_ex_mem_en && w_misalign) begin
                        o_misalign_exc <= 1'b1;
                    end else if (w_accept) begin
                        r_state     <= ACCESS;
                        r_cnt       <= 8'd0;
                        r_we        <= i_ex_mem_we;
                        r_is_b      <= w_is_b;
                        r_is_h      <= w_is_h;
                        r_uns       <= w_uns;
                        r_lane      <= i_ex_alu_out[1:0];
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_ex_mem_we;
                        o_bus_addr  <= {i_ex_alu_out[ADDR_W-1:2], 2'b00};
                        o_bus_be    <= w_be;
                        o_bus_wdata <= w_wdata;
                    end
                end
                ACCESS: begin
                    if (i_bus_ack || r_cnt == CNT_LAST) begin
                        r_state     <= DONE;
                        r_cnt       <= 8'd0;
                        o_bus_req   <= 1'b0;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= '0;
                        o_bus_be    <= 4'd0;
                        o_bus_wdata <= '0;
                        if (i_bus_ack && !r_we)
                            o_mem_data_to_gpr <= w_load;
                        if (!i_bus_ack)
                            o_bus_err_exc <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. The stimulus is directed and
// randomized load/store transactions. A transaction-level reference model
// predicts the byte enables, the store lanes, the extended load data, the
// stall length and the exceptions.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, we, ack;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    logic        bus_req, bus_we, stall, mis, berr;
    logic [31:0] bus_addr, bus_wdata, gpr;
    logic [3:0]  bus_be;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [31:0] ref_data = 32'd0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .i_clk(clk), .i_reset(rst_n), .i_ex_mem_en(en), .i_ex_mem_we(we),
        .i_ex_funct3(f3), .i_ex_alu_out(addr), .i_ex_store_data(sdata),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_be(bus_be), .o_bus_wdata(bus_wdata), .i_bus_rdata(rdata),
        .i_bus_ack(ack), .o_mem_stall(stall), .o_mem_data_to_gpr(gpr),
        .o_misalign_exc(mis), .o_bus_err_exc(berr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes from the instruction fields.
    function automatic int unsigned m_size(input logic w, input logic [2:0] f);
        case (f)
            3'd0: return 1;
            3'd1: return 2;
            3'd4: return w ? 4 : 1;
            3'd5: return w ? 4 : 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input int unsigned sz, input logic uns);
        longint unsigned v, span;
        if (sz == 4) return rd;
        span = 64'd1 << (8 * sz);
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // Run one request. dly = number of ACCESS cycles before ack (0 = ack in
    // the first cycle). A negative dly means the bus never answers.
    task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int dly);
        int unsigned sz;
        logic        uns;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          n_acc;
        int          exp_acc;
        sz  = m_size(w, f);
        uns = (f == 3'd4 || f == 3'd5) && !w;
        @(negedge clk);
        en = 1'b1; we = w; f3 = f; addr = a; sdata = sd;
        #1;
        if ((a % sz) != 0) begin
            chk("mis_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1 en = 1'b0;
            @(negedge clk);
            chk("mis_pulse", {31'd0, mis}, 32'd1);
            chk("mis_req", {31'd0, bus_req}, 32'd0);
            chk("mis_data", gpr, ref_data);
            @(negedge clk);
            chk("mis_width", {31'd0, mis}, 32'd0);
            return;
        end
        chk("acc_stall0", {31'd0, stall}, 32'd1);
        ebe = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << (a % 4));
        ewd = (sz == 1) ? sd[7:0] * 32'h01010101 :
              (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
        @(posedge clk); #1 en = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!bus_req) break;
            if (n_acc == 0) begin
                chk("we", {31'd0, bus_we}, {31'd0, w});
                chk("addr", bus_addr, a & 32'hFFFF_FFFC);
                chk("be", {28'd0, bus_be}, {28'd0, ebe});
                if (w) chk("wdata", bus_wdata, ewd);
            end
            if (!stall) chk("acc_stall", {31'd0, stall}, 32'd1);
            if (n_acc == dly) begin ack = 1'b1; rdata = rd; end
            n_acc++;
            @(posedge clk); #1 ack = 1'b0; rdata = $urandom;
        end
        exp_acc = (dly < 0) ? 255 : dly + 1;
        chk("acc_cycles", n_acc, exp_acc);
        if (dly >= 0 && !w) ref_data = m_load(rd, a, sz, uns);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_berr", {31'd0, berr}, {31'd0, dly < 0});
        chk("done_data", gpr, ref_data);
        @(negedge clk);
        chk("idle_berr", {31'd0, berr}, 32'd0);
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        en = 0; we = 0; f3 = 0; addr = 0; sdata = 0; rdata = 0; ack = 0; rst_n = 0;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_gpr", gpr, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_const", gpr, 32'hDEADBEEF);
        txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 0);
        chk("lb_const", gpr, 32'hFFFFFF80);
        txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 1);
        chk("lbu_const", gpr, 32'h00000080);
        txn(1'b0, 3'd5, 32'h102, 32'h0, 32'h80123456, 2);
        chk("lhu_const", gpr, 32'h00008012);
        txn(1'b1, 3'd0, 32'h101, 32'h000000AB, 32'h0, 0);
        txn(1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 3);
        txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
        txn(1'b0, 3'd2, 32'h104, 32'h0, 32'h0, -1);

        // Reset in the middle of ACCESS, then an ack that arrives too late.
        @(negedge clk);
        en = 1'b1; we = 1'b0; f3 = 3'd2; addr = 32'h200;
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk);
        chk("mid_req", {31'd0, bus_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ref_data = 32'd0;
        chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        ack = 1'b1; rdata = 32'hCAFEF00D;
        @(negedge clk);
        ack = 1'b0;
        chk("late_ack_req", {31'd0, bus_req}, 32'd0);
        chk("late_ack_data", gpr, 32'd0);
        txn(1'b0, 3'd2, 32'h208, 32'h0, 32'h13579BDF, 0);

        // Randomized transactions.
        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] a;
            w = 1'($urandom);
            f = f3_tab[$urandom_range(0, 7)];
            a = 32'h1000 + $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a & ~(m_size(w, f) - 1);
            txn(w, f, a, $urandom, $urandom, int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
